burst_rr_arbiter: RTL

- N:1 round-robin arbiter for a shared multi-beat resource, such as a bus port or a memory write channel.
- The winner holds the grant for a whole burst of req_len+1 beats. Arbitration runs again only after the last beat is accepted.
- Sits between PORT requesters and a single resource that signals per-beat acceptance with beat_ready.

---
 rtl/burst_rr_arbiter_pkg.sv | 21 ++
 rtl/burst_rr_arbiter_if.sv | 34 +++
 rtl/burst_rr_arbiter_rr_pick.sv | 42 ++++
 rtl/burst_rr_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/burst_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parammod_arb_pkg
// Description : Shared types and helpers for the burst round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package parammod_arb_pkg;

    // Two-state arbiter FSM encoding
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Increment an index modulo port (port need not be a power of two)
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned port);
        return (idx + 32'd1 >= port) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/burst_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : burst_rr_arbiter_if
// Description : Request/grant/beat handshake bundle between requesters,
//               the shared resource and the burst round-robin arbiter.
//               slave  = arbiter view, master = requester/resource view.
// Revision    : 1.0 - initial release
// ============================================================================
interface burst_rr_arbiter_if #(
    parameter int PORT  = 4,
    parameter int LEN_W = 4
);
    localparam int IDX = $clog2(PORT);

    logic                    stall;
    logic [PORT-1:0]         req;
    logic [PORT*LEN_W-1:0]   req_len;
    logic                    beat_ready;
    logic [PORT-1:0]         gnt;
    logic [IDX-1:0]          gnt_idx;
    logic                    gnt_valid;
    logic                    gnt_last;

    modport slave (
        input  stall, req, req_len, beat_ready,
        output gnt, gnt_idx, gnt_valid, gnt_last
    );

    modport master (
        output stall, req, req_len, beat_ready,
        input  gnt, gnt_idx, gnt_valid, gnt_last
    );
endinterface
`default_nettype wire

// File: rtl/burst_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority select. Returns the first set
//               request at or after ptr, scanning upward and wrapping at
//               PORT (valid for non-power-of-two PORT).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int PORT = 4,
    parameter int IDX  = $clog2(PORT)
) (
    input  wire logic [PORT-1:0] req,
    input  wire logic [IDX-1:0]  ptr,
    output logic                 found,
    output logic [IDX-1:0]       idx,
    output logic [PORT-1:0]      onehot
);
    // Scan PORT positions starting at ptr; first hit wins
    always_comb begin
        int             j;
        logic [IDX-1:0] j_idx;
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        j_idx  = '0;
        for (int k = 0; k < PORT; k++) begin
            j = int'(ptr) + k;
            if (j >= PORT) begin
                j = j - PORT;
            end
            j_idx = IDX'(j);
            if (!found && req[j_idx]) begin
                found         = 1'b1;
                idx           = j_idx;
                onehot[j_idx] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/burst_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : burst_rr_arbiter
// Description : PORT:1 round-robin arbiter granting whole bursts of
//               req_len+1 beats. Optional macro BURST_RR_BACK2BACK_EN
//               re-arbitrates on the accepted last beat, removing the
//               one-cycle bubble between bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_rr_arbiter
    import parammod_arb_pkg::*;
#(
    parameter int PORT  = 4,
    parameter int LEN_W = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    burst_rr_arbiter_if.slave       bus
);
    localparam int IDX = $clog2(PORT);

    localparam logic [0:0] c_ST_IDLE  = ARB_IDLE;
    localparam logic [0:0] c_ST_BURST = ARB_BURST;

    logic [0:0]        state_q, state_d;
    logic [IDX-1:0]    ptr_q, ptr_d;
    logic [IDX-1:0]    owner_q, owner_d;
    logic [PORT-1:0]   owner_oh_q, owner_oh_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    logic              w_found;
    logic [IDX-1:0]    w_pick_idx;
    logic [PORT-1:0]   w_pick_onehot;
    logic [LEN_W-1:0]  w_len;
    logic [IDX-1:0]    w_ptr_next;
    logic              w_gnt_valid;
    logic              w_accept;
    logic              w_last;
    logic              w_take;

    // The pointer already sits one past the current owner, so the same
    // picker instance serves both IDLE arbitration and the back-to-back path.
    rr_pick #(.PORT(PORT), .IDX(IDX)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .found  (w_found),
        .idx    (w_pick_idx),
        .onehot (w_pick_onehot)
    );

    assign w_ptr_next  = IDX'(wrap_inc(32'(w_pick_idx), 32'(PORT)));
    assign w_gnt_valid = (state_q == c_ST_BURST) && !bus.stall;
    assign w_accept    = w_gnt_valid && bus.beat_ready;
    assign w_last      = (cnt_q == '0);

    assign bus.gnt       = w_gnt_valid ? owner_oh_q : '0;
    assign bus.gnt_idx   = w_gnt_valid ? owner_q : '0;
    assign bus.gnt_valid = w_gnt_valid;
    assign bus.gnt_last  = w_last && w_gnt_valid;

    // Burst length of the candidate winner
    always_comb begin
        w_len = '0;
        for (int i = 0; i < PORT; i++) begin
            if (w_pick_onehot[i]) begin
                w_len = bus.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Next-state: arbitrate in IDLE, count beats in BURST
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        cnt_d      = cnt_q;
        w_take     = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (!bus.stall && w_found) begin
                    w_take = 1'b1;
                end
            end
            default: begin
                // w_accept already implies stall is low
                if (w_accept) begin
                    if (!w_last) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
`ifdef BURST_RR_BACK2BACK_EN
                        if (w_found) begin
                            w_take = 1'b1;
                        end else begin
                            state_d = c_ST_IDLE;
                        end
`else
                        state_d = c_ST_IDLE;
`endif
                    end
                end
            end
        endcase
        if (w_take) begin
            state_d    = c_ST_BURST;
            owner_d    = w_pick_idx;
            owner_oh_d = w_pick_onehot;
            cnt_d      = w_len;
            ptr_d      = w_ptr_next;
        end
    end

    // State registers; reset abandons any partial burst immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= c_ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            owner_oh_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
`default_nettype wire
